// File: rtl/testbasic7_types.sv
// Shared types and constants for the testbasic7 feeder.
package testbasic7_types;

    localparam int unsigned FEEDER_DEPTH_DEF = 4;
    localparam int unsigned FEEDER_DATA_W    = 32;
    localparam int unsigned FEEDER_DROP_W    = 16;

    // Occupancy section of the feeder FIFO
    typedef enum logic [1:0] {
        idle      = 2'd0,
        streaming = 2'd1,
        full      = 2'd2
    } TestBasic7_FEEDER_SECTIONS;

    // Saturating add for the flush drop counter
    function automatic logic [FEEDER_DROP_W-1:0] drop_sat_add(
        input logic [FEEDER_DROP_W-1:0] acc,
        input logic [FEEDER_DROP_W-1:0] inc
    );
        logic [FEEDER_DROP_W:0] sum;
        sum = (FEEDER_DROP_W+1)'(acc) + (FEEDER_DROP_W+1)'(inc);
        if (sum[FEEDER_DROP_W]) begin
            return {FEEDER_DROP_W{1'b1}};
        end
        return sum[FEEDER_DROP_W-1:0];
    endfunction

endpackage

// File: rtl/testbasic7_feeder_mem.sv
// DEPTH x 32 storage for the feeder: one write port, one registered
// write-first read port. Contents are not reset; only the read register is.
module testbasic7_feeder_mem
    import testbasic7_types::*;
#(
    parameter int unsigned DEPTH = FEEDER_DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [FEEDER_DATA_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic [FEEDER_DATA_W-1:0] rdata
);

    logic [FEEDER_DATA_W-1:0] mem [DEPTH];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-cycle write to the read slot is forwarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/testbasic7_feeder.sv
// Buffered producer feeding testbasic7's blocking input. A DEPTH-entry FIFO
// decouples source bursts from consumer stalls; a section FSM tracks
// occupancy. Optional synchronous flush (with drop counter) is enabled by
// defining TESTBASIC7_FEEDER_FLUSH_EN.
module testbasic7_feeder
    import testbasic7_types::*;
#(
    parameter int unsigned DEPTH = FEEDER_DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FEEDER_DATA_W-1:0] src_in,
    input  logic                     src_in_sync,
    output logic                     src_in_notify,
    output logic [FEEDER_DATA_W-1:0] b_out,
    output logic                     b_out_sync,
    input  logic                     b_out_notify,
`ifdef TESTBASIC7_FEEDER_FLUSH_EN
    input  logic                     flush,
`endif
    output logic [FEEDER_DROP_W-1:0] drop_count
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    logic [AW-1:0]             wp;
    logic [AW-1:0]             rp;
    logic [AW-1:0]             wp_n;
    logic [AW-1:0]             rp_n;
    logic [CW-1:0]             count;
    logic [CW-1:0]             count_n;
    TestBasic7_FEEDER_SECTIONS section;
    TestBasic7_FEEDER_SECTIONS section_n;
    logic                      push;
    logic                      pop;
    logic                      flush_w;

`ifdef TESTBASIC7_FEEDER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Source may push whenever the FIFO is not full
    assign src_in_notify = (count != COUNT_FULL);

    // Next-state: handshakes, pointers, count and section transitions
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        wp_n      = wp;
        rp_n      = rp;
        count_n   = count;
        section_n = section;

        if (flush_w) begin
            wp_n      = '0;
            rp_n      = '0;
            count_n   = '0;
            section_n = idle;
        end else begin
            push = src_in_sync && src_in_notify;
            pop  = b_out_sync && b_out_notify;

            if (push) begin
                wp_n = wp + AW'(1);
            end
            if (pop) begin
                rp_n = rp + AW'(1);
            end

            case ({push, pop})
                2'b10:   count_n = count + COUNT_ONE;
                2'b01:   count_n = count - COUNT_ONE;
                default: count_n = count;
            endcase

            case (section)
                idle: begin
                    if (push) begin
                        section_n = streaming;
                    end
                end
                streaming: begin
                    if (push && !pop && (count == COUNT_LAST)) begin
                        section_n = full;
                    end else if (pop && !push && (count == COUNT_ONE)) begin
                        section_n = idle;
                    end
                end
                full: begin
                    if (pop) begin
                        section_n = streaming;
                    end
                end
                default: section_n = idle;
            endcase
        end
    end

    // State register: pointers, count, section and output valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            section    <= idle;
            b_out_sync <= 1'b0;
        end else begin
            wp         <= wp_n;
            rp         <= rp_n;
            count      <= count_n;
            section    <= section_n;
            b_out_sync <= (section_n != idle);
        end
    end

    // Storage; read address tracks the next head so b_out is ready with b_out_sync
    testbasic7_feeder_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wp),
        .wdata (src_in),
        .raddr (rp_n),
        .rdata (b_out)
    );

`ifdef TESTBASIC7_FEEDER_FLUSH_EN
    // Accumulate words discarded by flush, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (flush_w) begin
            drop_count <= drop_sat_add(drop_count, FEEDER_DROP_W'(count));
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_testbasic7_feeder.sv
// Self-checking bench for testbasic7_feeder: randomized and directed stimulus
// against a queue-based reference model of the FIFO.
module tb_testbasic7_feeder;
    import testbasic7_types::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_in;
    logic        src_in_sync;
    logic        src_in_notify;
    logic [31:0] b_out;
    logic        b_out_sync;
    logic        b_out_notify;
    logic [15:0] drop_count;
`ifdef TESTBASIC7_FEEDER_FLUSH_EN
    logic        flush;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          exp_drop = 0;
    bit          last_acc;
    bit          last_pop;
    logic [31:0] pop_dut;
    logic [31:0] pop_exp;
    logic        fl = 1'b0;

    always #5 clk = ~clk;

    testbasic7_feeder #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_in        (src_in),
        .src_in_sync   (src_in_sync),
        .src_in_notify (src_in_notify),
        .b_out         (b_out),
        .b_out_sync    (b_out_sync),
        .b_out_notify  (b_out_notify),
`ifdef TESTBASIC7_FEEDER_FLUSH_EN
        .flush         (flush),
`endif
        .drop_count    (drop_count)
    );

    // One clock of stimulus; the reference queue advances with the same transfer rule
    task automatic drive_cycle(input logic s, input logic [31:0] d, input logic n);
        int size0;
        last_pop = 0;
        last_acc = 0;
        src_in_sync  = s;
        src_in       = d;
        b_out_notify = n;
`ifdef TESTBASIC7_FEEDER_FLUSH_EN
        flush = fl;
`endif
        size0 = exp_q.size();
        if (fl) begin
            exp_drop = (exp_drop + size0 > 65535) ? 65535 : exp_drop + size0;
            exp_q.delete();
        end else begin
            if (n && size0 != 0) begin
                last_pop = 1;
                pop_dut  = b_out;
                pop_exp  = exp_q.pop_front();
            end
            if (s && size0 < DEPTH) begin
                last_acc = 1;
                exp_q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (b_out_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got=%0b exp=0", b_out_sync); end
        checks++; if (src_in_notify !== 1'b1) begin errors++; $display("FAIL reset_notify got=%0b exp=1", src_in_notify); end
        checks++; if (b_out !== 32'd0) begin errors++; $display("FAIL reset_bout got=%0d exp=0", b_out); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if (dut.section !== idle) begin errors++; $display("FAIL reset_section got=%0d exp=%0d", dut.section, idle); end
        #3 rst = 1'b1;
        @(posedge clk); #1;
        drive_cycle(1'b1, 32'hA1, 1'b0);
        drive_cycle(1'b1, 32'hA2, 1'b0);
        checks++; if (b_out_sync !== 1'b1) begin errors++; $display("FAIL burst_sync got=%0b exp=1", b_out_sync); end
        checks++; if (b_out !== 32'hA1) begin errors++; $display("FAIL burst_head got=%0h exp=a1", b_out); end
        // Asynchronous reset in the middle of a cycle
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (b_out_sync !== 1'b0) begin errors++; $display("FAIL midrst_sync got=%0b exp=0", b_out_sync); end
        checks++; if (src_in_notify !== 1'b1) begin errors++; $display("FAIL midrst_notify got=%0b exp=1", src_in_notify); end
        checks++; if (dut.section !== idle) begin errors++; $display("FAIL midrst_section got=%0d exp=%0d", dut.section, idle); end
        checks++; if (b_out !== 32'd0) begin errors++; $display("FAIL midrst_bout got=%0h exp=0", b_out); end
        src_in_sync = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        drive_cycle(1'b0, 32'd0, 1'b1);
        drive_cycle(1'b0, 32'd0, 1'b1);
        checks++; if (b_out_sync !== 1'b0) begin errors++; $display("FAIL stale_sync got=%0b exp=0", b_out_sync); end
    endtask

    task automatic test_pass_through();
        drive_cycle(1'b1, 32'd1337, 1'b1);
        checks++; if (b_out_sync !== 1'b1) begin errors++; $display("FAIL pass_sync got=%0b exp=1", b_out_sync); end
        checks++; if (b_out !== 32'd1337) begin errors++; $display("FAIL pass_data got=%0d exp=1337", b_out); end
        drive_cycle(1'b0, 32'd0, 1'b1);
        checks++; if (!(last_pop && pop_dut === 32'd1337)) begin errors++; $display("FAIL pass_pop got=%0d exp=1337", pop_dut); end
        checks++; if (b_out_sync !== 1'b0) begin errors++; $display("FAIL pass_empty got=%0b exp=0", b_out_sync); end
    endtask

    task automatic test_fill();
        int next_val;
        int delivered;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 32'(10 + i), 1'b0);
        end
        checks++; if (src_in_notify !== 1'b0) begin errors++; $display("FAIL fill_notify got=%0b exp=0", src_in_notify); end
        checks++; if (dut.section !== full) begin errors++; $display("FAIL fill_section got=%0d exp=%0d", dut.section, full); end
        drive_cycle(1'b1, 32'd14, 1'b0);
        checks++; if (src_in_notify !== 1'b0) begin errors++; $display("FAIL fill_block got=%0b exp=0", src_in_notify); end
        checks++; if (b_out !== 32'd10) begin errors++; $display("FAIL fill_head got=%0d exp=10", b_out); end
        next_val  = 14;
        delivered = 0;
        cyc       = 0;
        while (delivered < 5 && cyc < 50) begin
            drive_cycle(next_val <= 14, 32'(next_val), 1'b1);
            if (last_acc) next_val++;
            cyc++;
            if (last_pop) begin
                delivered++;
                checks++; if (pop_dut !== pop_exp) begin errors++; $display("FAIL fill_order got=%0d exp=%0d", pop_dut, pop_exp); end
            end
            checks++; if (b_out_sync !== (exp_q.size() != 0)) begin errors++; $display("FAIL fill_sync got=%0b exp=%0b", b_out_sync, exp_q.size() != 0); end
        end
        checks++; if (delivered != 5) begin errors++; $display("FAIL fill_count got=%0d exp=5", delivered); end
    endtask

    task automatic test_throughput();
        int pops = 0;
        for (int i = 0; i < 100; i++) begin
            drive_cycle(1'b1, 32'(1000 + i), 1'b1);
            if (last_pop) begin
                pops++;
                checks++; if (pop_dut !== pop_exp) begin errors++; $display("FAIL tput_data got=%0d exp=%0d", pop_dut, pop_exp); end
            end
            checks++; if (src_in_notify !== 1'b1 || b_out_sync !== 1'b1) begin errors++; $display("FAIL tput_hs got=%0b%0b exp=11", src_in_notify, b_out_sync); end
            checks++; if (b_out !== exp_q[0]) begin errors++; $display("FAIL tput_head got=%0d exp=%0d", b_out, exp_q[0]); end
        end
        checks++; if (pops != 99) begin errors++; $display("FAIL tput_pops got=%0d exp=99", pops); end
        drive_cycle(1'b0, 32'd0, 1'b1);
        checks++; if (!(last_pop && pop_dut === 32'd1099)) begin errors++; $display("FAIL tput_last got=%0d exp=1099", pop_dut); end
        checks++; if (b_out_sync !== 1'b0) begin errors++; $display("FAIL tput_drain got=%0b exp=0", b_out_sync); end
    endtask

    task automatic test_wrap();
        logic [31:0] words[3*DEPTH+1];
        int k = 0;
        int delivered = 0;
        int cyc = 0;
        for (int i = 0; i < 3 * DEPTH + 1; i++) words[i] = $urandom;
        while (delivered < 3 * DEPTH + 1 && cyc < 2000) begin
            drive_cycle(k < 3 * DEPTH + 1 && $urandom_range(0, 2) != 0,
                        (k < 3 * DEPTH + 1) ? words[k] : 32'd0,
                        $urandom_range(0, 2) != 0);
            if (last_acc) k++;
            cyc++;
            if (last_pop) begin
                checks++; if (pop_dut !== words[delivered]) begin errors++; $display("FAIL wrap_data got=%0h exp=%0h", pop_dut, words[delivered]); end
                delivered++;
            end
            checks++; if (src_in_notify !== (exp_q.size() != DEPTH)) begin errors++; $display("FAIL wrap_notify got=%0b exp=%0b", src_in_notify, exp_q.size() != DEPTH); end
            checks++; if (b_out_sync !== (exp_q.size() != 0)) begin errors++; $display("FAIL wrap_sync got=%0b exp=%0b", b_out_sync, exp_q.size() != 0); end
        end
        checks++; if (delivered != 3 * DEPTH + 1) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", delivered, 3 * DEPTH + 1); end
    endtask

`ifdef TESTBASIC7_FEEDER_FLUSH_EN
    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'(50 + i), 1'b0);
        fl = 1'b1;
        drive_cycle(1'b0, 32'd0, 1'b0);
        fl = 1'b0;
        checks++; if (b_out_sync !== 1'b0) begin errors++; $display("FAIL flush_sync got=%0b exp=0", b_out_sync); end
        checks++; if (src_in_notify !== 1'b1) begin errors++; $display("FAIL flush_notify got=%0b exp=1", src_in_notify); end
        checks++; if (drop_count !== 16'(exp_drop)) begin errors++; $display("FAIL flush_drop got=%0d exp=%0d", drop_count, exp_drop); end
        checks++; if (dut.section !== idle) begin errors++; $display("FAIL flush_section got=%0d exp=%0d", dut.section, idle); end
        drive_cycle(1'b1, 32'd77, 1'b1);
        checks++; if (b_out_sync !== 1'b1 || b_out !== 32'd77) begin errors++; $display("FAIL flush_next got=%0d exp=77", b_out); end
        drive_cycle(1'b0, 32'd0, 1'b1);
        checks++; if (!(last_pop && pop_dut === 32'd77)) begin errors++; $display("FAIL flush_pop got=%0d exp=77", pop_dut); end
    endtask
`endif

    initial begin
        rst          = 1'b0;
        src_in       = '0;
        src_in_sync  = 1'b0;
        b_out_notify = 1'b0;
`ifdef TESTBASIC7_FEEDER_FLUSH_EN
        flush        = 1'b0;
`endif
        #1;
        test_reset();
        test_pass_through();
        test_fill();
        test_throughput();
        test_wrap();
`ifdef TESTBASIC7_FEEDER_FLUSH_EN
        test_flush();
`endif
        checks++; if (drop_count !== 16'(exp_drop)) begin errors++; $display("FAIL final_drop got=%0d exp=%0d", drop_count, exp_drop); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
